// File: rtl/note_hit_judge.sv
// ---------------------------------------------------------------------------
// note_hit_judge
//
// Purpose: judges fret-key presses against the note sprites of a five-lane
// rhythm game. A press on a lane is a hit when that lane's sprite row lies in
// the strum window and the lane has not already been hit since the sprite
// last left the window. Hits bump the streak and add a streak-dependent
// increment to a four-digit BCD score, one digit per cycle.
//
// Ports:
//   Clk            system clock (the only clock)
//   Reset          synchronous, active-high reset
//   frame_clk      VGA vertical sync level, asynchronous, synchronized here
//   keycode[7:0]   USB HID keycode
//   *_y_pos[9:0]   sprite rows for green, red, yellow, blue, orange lanes
//   score[15:0]    four BCD digits, [3:0] is the ones digit
//   streak[7:0]    consecutive hits, saturating at 255
//   hit_pulse[4:0] one-hot lane strobe {orange,blue,yellow,red,green}
//   miss_pulse     miss strobe
//   busy           high while a judgement or score update is in progress
//
// Build option:
//   STREAK_MULT_EN  when defined, increment = 1 + min(streak/8, 3);
//                   otherwise every hit adds 1.
// ---------------------------------------------------------------------------
module note_hit_judge #(
    parameter logic [9:0] HIT_Y_MIN = 10'd420,
    parameter logic [9:0] HIT_Y_MAX = 10'd460
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic [9:0]  green_y_pos,
    input  logic [9:0]  red_y_pos,
    input  logic [9:0]  yellow_y_pos,
    input  logic [9:0]  blue_y_pos,
    input  logic [9:0]  orange_y_pos,
    output logic [15:0] score,
    output logic [7:0]  streak,
    output logic [4:0]  hit_pulse,
    output logic        miss_pulse,
    output logic        busy
);

    localparam int NUM_LANES = 5;

    typedef enum logic [2:0] {
        WAIT,
        JUDGE,
        ADD0,
        ADD1,
        ADD2,
        ADD3
    } state_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t               r_state_reg;
    logic [7:0]           r_key_reg;
    logic [2:0]           r_fsync_reg;     // [1:0] synchronizer, [2] last synced level
    logic [NUM_LANES-1:0] r_lane_oh_reg;   // lane latched at the press, one-hot
    logic [NUM_LANES-1:0] r_lock_reg;
    logic [7:0]           r_streak_reg;
    logic [15:0]          r_score_reg;
    logic [15:0]          r_work_reg;      // digit-serial working copy of the score
    logic [2:0]           r_inc_reg;
    logic                 r_carry_reg;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    state_t               w_state_next;
    logic [9:0]           w_y_pos [NUM_LANES];
    logic [NUM_LANES-1:0] w_in_win;
    logic [NUM_LANES-1:0] w_key_lane_oh;
    logic                 w_press;
    logic                 w_frame_edge;
    logic                 w_judge_ok;
    logic                 w_hit;
    logic                 w_miss;
    logic [NUM_LANES-1:0] w_lock_next;
    logic [2:0]           w_inc;
    logic [3:0]           w_digit;
    logic [2:0]           w_addend;
    logic [4:0]           w_digit_sum;
    logic [4:0]           w_digit_adj;
    logic                 w_digit_carry;
    logic [3:0]           w_digit_new;

    // -----------------------------------------------------------------------
    // Lane geometry
    // -----------------------------------------------------------------------
    assign w_y_pos[0] = green_y_pos;
    assign w_y_pos[1] = red_y_pos;
    assign w_y_pos[2] = yellow_y_pos;
    assign w_y_pos[3] = blue_y_pos;
    assign w_y_pos[4] = orange_y_pos;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_window
            assign w_in_win[gi] = (w_y_pos[gi] >= HIT_Y_MIN) &&
                                  (w_y_pos[gi] <= HIT_Y_MAX);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Key decode and press detection
    // -----------------------------------------------------------------------
    always_comb begin
        w_key_lane_oh = '0;
        case (keycode)
            8'h04:   w_key_lane_oh = 5'b00001;  // green
            8'h16:   w_key_lane_oh = 5'b00010;  // red
            8'h07:   w_key_lane_oh = 5'b00100;  // yellow
            8'h09:   w_key_lane_oh = 5'b01000;  // blue
            8'h0A:   w_key_lane_oh = 5'b10000;  // orange
            default: w_key_lane_oh = '0;
        endcase
    end

    // A held key keeps the same code, so only a change onto a lane code counts.
    assign w_press = (|w_key_lane_oh) && (keycode != r_key_reg);

    // Rising edge of the synchronized vertical sync.
    assign w_frame_edge = r_fsync_reg[1] & ~r_fsync_reg[2];

    // -----------------------------------------------------------------------
    // Increment selection (uses the streak before this hit is counted)
    // -----------------------------------------------------------------------
`ifdef STREAK_MULT_EN
    assign w_inc = (r_streak_reg >= 8'd24) ? 3'd4 : (3'd1 + {1'b0, r_streak_reg[4:3]});
`else
    assign w_inc = 3'd1;
`endif

    // -----------------------------------------------------------------------
    // FSM next state and strobes
    // -----------------------------------------------------------------------
    assign w_judge_ok = |(r_lane_oh_reg & w_in_win & ~r_lock_reg);

    always_comb begin
        w_state_next = r_state_reg;
        w_hit        = 1'b0;
        w_miss       = 1'b0;
        case (r_state_reg)
            WAIT: begin
                if (w_press) begin
                    w_state_next = JUDGE;
                end
            end
            JUDGE: begin
                if (w_judge_ok) begin
                    w_hit        = 1'b1;
                    w_state_next = ADD0;
                end else begin
                    w_miss       = 1'b1;
                    w_state_next = WAIT;
                end
            end
            ADD0:    w_state_next = ADD1;
            ADD1:    w_state_next = ADD2;
            ADD2:    w_state_next = ADD3;
            ADD3:    w_state_next = WAIT;
            default: w_state_next = WAIT;
        endcase
    end

    // Lock update: the judgement sets the lock first, then a coinciding frame
    // edge releases every lane whose sprite is outside the window.
    always_comb begin
        w_lock_next = r_lock_reg;
        if (w_hit) begin
            w_lock_next = w_lock_next | r_lane_oh_reg;
        end
        if (w_frame_edge) begin
            w_lock_next = w_lock_next & w_in_win;
        end
    end

    // -----------------------------------------------------------------------
    // Single BCD digit adder shared by the four ADD states
    // -----------------------------------------------------------------------
    always_comb begin
        w_digit  = 4'd0;
        w_addend = 3'd0;
        case (r_state_reg)
            ADD0: begin
                w_digit  = r_work_reg[3:0];
                w_addend = r_inc_reg;
            end
            ADD1: begin
                w_digit  = r_work_reg[7:4];
                w_addend = {2'b00, r_carry_reg};
            end
            ADD2: begin
                w_digit  = r_work_reg[11:8];
                w_addend = {2'b00, r_carry_reg};
            end
            ADD3: begin
                w_digit  = r_work_reg[15:12];
                w_addend = {2'b00, r_carry_reg};
            end
            default: begin
                w_digit  = 4'd0;
                w_addend = 3'd0;
            end
        endcase
    end

    // Max sum is 9 + 4 = 13, so at most one decimal wrap per digit.
    assign w_digit_sum   = {1'b0, w_digit} + {2'b00, w_addend};
    assign w_digit_adj   = w_digit_sum - 5'd10;
    assign w_digit_carry = (w_digit_sum > 5'd9);
    assign w_digit_new   = w_digit_carry ? w_digit_adj[3:0] : w_digit_sum[3:0];

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fsync_reg <= '0;
        end else begin
            r_fsync_reg <= {r_fsync_reg[1:0], frame_clk};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state_reg   <= WAIT;
            r_key_reg     <= '0;
            r_lane_oh_reg <= '0;
            r_lock_reg    <= '0;
            r_streak_reg  <= '0;
            r_score_reg   <= '0;
            r_work_reg    <= '0;
            r_inc_reg     <= '0;
            r_carry_reg   <= 1'b0;
        end else begin
            r_state_reg <= w_state_next;
            r_key_reg   <= keycode;
            r_lock_reg  <= w_lock_next;

            if ((r_state_reg == WAIT) && w_press) begin
                r_lane_oh_reg <= w_key_lane_oh;
            end

            if (w_hit) begin
                r_streak_reg <= (r_streak_reg == 8'hFF) ? 8'hFF : (r_streak_reg + 8'd1);
                r_inc_reg    <= w_inc;
                r_work_reg   <= r_score_reg;
                r_carry_reg  <= 1'b0;
            end

            if (w_miss) begin
                r_streak_reg <= '0;
            end

            // Digits are rewritten in place in the working copy; the visible
            // score only changes once the top digit has been resolved.
            case (r_state_reg)
                ADD0: begin
                    r_work_reg[3:0] <= w_digit_new;
                    r_carry_reg     <= w_digit_carry;
                end
                ADD1: begin
                    r_work_reg[7:4] <= w_digit_new;
                    r_carry_reg     <= w_digit_carry;
                end
                ADD2: begin
                    r_work_reg[11:8] <= w_digit_new;
                    r_carry_reg      <= w_digit_carry;
                end
                ADD3: begin
                    r_work_reg[15:12] <= w_digit_new;
                    r_carry_reg       <= 1'b0;
                    if (w_digit_carry) begin
                        r_score_reg <= 16'h9999;
                    end else begin
                        r_score_reg <= {w_digit_new, r_work_reg[11:0]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign score      = r_score_reg;
    assign streak     = r_streak_reg;
    assign hit_pulse  = w_hit ? r_lane_oh_reg : '0;
    assign miss_pulse = w_miss;
    assign busy       = (r_state_reg != WAIT);

endmodule

// File: tb/tb_note_hit_judge.sv
module tb_note_hit_judge;

    localparam logic [9:0] Y_MIN = 10'd420;
    localparam logic [9:0] Y_MAX = 10'd460;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic [9:0]  ys [5];
    logic [15:0] score;
    logic [7:0]  streak;
    logic [4:0]  hit_pulse;
    logic        miss_pulse;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference state
    int         m_score;
    int         m_streak;
    bit         m_lock [5];
    logic [7:0] m_prev_key;
    int         climb_idx;

    logic [7:0] lane_codes [5] = '{8'h04, 8'h16, 8'h07, 8'h09, 8'h0A};
    logic [7:0] rnd_codes  [8] = '{8'h00, 8'h04, 8'h16, 8'h07, 8'h09, 8'h0A, 8'h05, 8'hFF};

    note_hit_judge #(
        .HIT_Y_MIN(Y_MIN),
        .HIT_Y_MAX(Y_MAX)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .keycode      (keycode),
        .green_y_pos  (ys[0]),
        .red_y_pos    (ys[1]),
        .yellow_y_pos (ys[2]),
        .blue_y_pos   (ys[3]),
        .orange_y_pos (ys[4]),
        .score        (score),
        .streak       (streak),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .busy         (busy)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int lane_of(input logic [7:0] code);
        case (code)
            8'h04:   return 0;
            8'h16:   return 1;
            8'h07:   return 2;
            8'h09:   return 3;
            8'h0A:   return 4;
            default: return -1;
        endcase
    endfunction

    function automatic bit in_win(input logic [9:0] y);
        return (y >= 10'd420) && (y <= 10'd460);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int model_inc();
`ifdef STREAK_MULT_EN
        return 1 + ((m_streak / 8 > 3) ? 3 : m_streak / 8);
`else
        return 1;
`endif
    endfunction

    // Apply a scoring hit to the model.
    task automatic model_hit();
        m_score  = (m_score + model_inc() > 9999) ? 9999 : m_score + model_inc();
        m_streak = (m_streak < 255) ? m_streak + 1 : 255;
    endtask

    task automatic model_reset();
        m_score    = 0;
        m_streak   = 0;
        m_prev_key = 8'h00;
        for (int i = 0; i < 5; i++) m_lock[i] = 1'b0;
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        keycode   = 8'h00;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
    endtask

    // One frame sync pulse with the current sprite rows held steady.
    task automatic frame_edge();
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        for (int i = 0; i < 5; i++) if (!in_win(ys[i])) m_lock[i] = 1'b0;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    // Present a keycode while idle and check the full resulting transaction.
    task automatic do_press(input logic [7:0] code, input string tag);
        int         lane;
        bit         press;
        bit         hit;
        int         old_score;
        logic [4:0] exp_hp;
        keycode   = code;
        lane      = lane_of(code);
        press     = (lane >= 0) && (code != m_prev_key);
        m_prev_key = code;
        old_score = m_score;
        @(negedge Clk);
        if (!press) begin
            check_eq({tag, ".hp"}, 32'(hit_pulse), 32'd0);
            check_eq({tag, ".mp"}, 32'(miss_pulse), 32'd0);
            check_eq({tag, ".busy"}, 32'(busy), 32'd0);
            $display("txn %s key=%02h no-press score=%04h", tag, code, score);
        end else begin
            hit    = in_win(ys[lane]) && !m_lock[lane];
            exp_hp = '0;
            if (hit) exp_hp[lane] = 1'b1;
            check_eq({tag, ".hp"}, 32'(hit_pulse), 32'(exp_hp));
            check_eq({tag, ".mp"}, 32'(miss_pulse), 32'(!hit));
            check_eq({tag, ".busy"}, 32'(busy), 32'd1);
            if (hit) begin
                model_hit();
                m_lock[lane] = 1'b1;
            end else begin
                m_streak = 0;
            end
            @(negedge Clk);
            check_eq({tag, ".hp_off"}, 32'(hit_pulse), 32'd0);
            check_eq({tag, ".mp_off"}, 32'(miss_pulse), 32'd0);
            check_eq({tag, ".streak"}, 32'(streak), 32'(m_streak));
            check_eq({tag, ".busy2"}, 32'(busy), 32'(hit));
            if (hit) begin
                repeat (3) @(negedge Clk);
                check_eq({tag, ".score_old"}, 32'(score), 32'(to_bcd(old_score)));
                @(negedge Clk);
                check_eq({tag, ".score_new"}, 32'(score), 32'(to_bcd(m_score)));
                check_eq({tag, ".busy_end"}, 32'(busy), 32'd0);
            end else begin
                check_eq({tag, ".score_kept"}, 32'(score), 32'(to_bcd(old_score)));
            end
            $display("txn %s key=%02h lane=%0d y=%0d %s streak=%0d score=%04h",
                     tag, code, lane, ys[lane], hit ? "hit" : "miss", streak, score);
        end
    endtask

    // Back-to-back hit rotating through the lanes. Each lane leaves the window
    // after its hit and returns four hits later; frame_clk toggles every hit,
    // so at least one frame edge sees it outside and releases its lock.
    task automatic fast_hit(input bit verbose);
        int         lane;
        int         old_score;
        logic [4:0] exp_hp;
        lane      = climb_idx % 5;
        keycode   = lane_codes[lane];
        m_prev_key = keycode;
        ys[(lane + 1) % 5] = 10'd430;
        frame_clk = ~frame_clk;
        old_score = m_score;
        exp_hp    = '0;
        exp_hp[lane] = 1'b1;
        @(negedge Clk);
        if (verbose) begin
            check_eq("climb.hp", 32'(hit_pulse), 32'(exp_hp));
            check_eq("climb.busy", 32'(busy), 32'd1);
        end
        model_hit();
        @(negedge Clk);
        ys[lane] = 10'd470;
        if (verbose) check_eq("climb.streak", 32'(streak), 32'(m_streak));
        repeat (3) @(negedge Clk);
        if (verbose) check_eq("climb.score_old", 32'(score), 32'(to_bcd(old_score)));
        @(negedge Clk);
        if (verbose) begin
            check_eq("climb.score_new", 32'(score), 32'(to_bcd(m_score)));
            check_eq("climb.busy_end", 32'(busy), 32'd0);
            $display("txn climb#%0d lane=%0d streak=%0d score=%04h", climb_idx, lane, streak, score);
        end
        climb_idx++;
    endtask

    task automatic climb_to(input int target, input int verbose_limit);
        while (m_score < target) fast_hit(climb_idx < verbose_limit);
        check_eq("climb.score", 32'(score), 32'(to_bcd(m_score)));
        check_eq("climb.streak_total", 32'(streak), 32'(m_streak));
        $display("txn climb_to %0d hits=%0d score=%04h streak=%0d", target, climb_idx, score, streak);
    endtask

    initial begin
        int r;
        for (int i = 0; i < 5; i++) ys[i] = 10'd100;
        @(negedge Clk);
        do_reset();
        check_eq("rst.score", 32'(score), 32'd0);
        check_eq("rst.streak", 32'(streak), 32'd0);
        check_eq("rst.hp", 32'(hit_pulse), 32'd0);
        check_eq("rst.mp", 32'(miss_pulse), 32'd0);
        check_eq("rst.busy", 32'(busy), 32'd0);
        $display("txn reset score=%04h streak=%0d busy=%0d", score, streak, busy);

        // Basic hit, miss outside the window, lock behaviour
        ys[0] = 10'd430;
        do_press(8'h00, "idle");
        do_press(8'h04, "green_hit");
        do_press(8'h16, "red_miss");
        do_press(8'h00, "release");
        do_press(8'h04, "green_locked");
        ys[0] = 10'd470;
        frame_edge();
        ys[0] = 10'd440;
        frame_edge();
        do_press(8'h00, "release2");
        do_press(8'h04, "green_rehit");

        // Randomized presses, sprite rows (including window borders), frame edges
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 5; i++) begin
                    r = $urandom_range(0, 5);
                    case (r)
                        0:       ys[i] = 10'd419;
                        1:       ys[i] = 10'd420;
                        2:       ys[i] = 10'd460;
                        3:       ys[i] = 10'd461;
                        4:       ys[i] = 10'd440;
                        default: ys[i] = 10'($urandom_range(300, 600));
                    endcase
                end
            end
            if ($urandom_range(0, 2) == 0) frame_edge();
            do_press(rnd_codes[$urandom_range(0, 7)], $sformatf("rnd%0d", t));
        end

        // Reset in the middle of a score update
        do_reset();
        for (int i = 0; i < 5; i++) ys[i] = 10'd430;
        do_press(8'h04, "pre_abort");
        keycode = 8'h07;
        @(negedge Clk);                      // JUDGE
        check_eq("abort.hp", 32'(hit_pulse), 32'h4);
        @(negedge Clk);                      // ADD0
        @(negedge Clk);                      // ADD1
        Reset   = 1'b1;
        keycode = 8'h00;
        @(negedge Clk);
        check_eq("abort.score", 32'(score), 32'd0);
        check_eq("abort.busy", 32'(busy), 32'd0);
        check_eq("abort.streak", 32'(streak), 32'd0);
        $display("txn abort_add1 score=%04h busy=%0d streak=%0d", score, busy, streak);
        Reset = 1'b0;
        model_reset();

        // Long climb: streak-dependent increments, 0999->1000 carry, 9999 saturation
        do_reset();
        for (int i = 0; i < 5; i++) ys[i] = 10'd430;
        climb_idx = 0;
        climb_to(999, 30);
        fast_hit(1'b1);
        climb_to(9999, 0);
        fast_hit(1'b1);
        check_eq("sat.score", 32'(score), 32'h9999);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/note_hit_judge.md
NOTE_HIT_JUDGE -- requirements
Module: note_hit_judge

Interface
REQ-001 SHALL have parameter HIT_Y_MIN, default 10'd420: top row of the strum window, inclusive.
REQ-002 SHALL have parameter HIT_Y_MAX, default 10'd460: bottom row of the strum window, inclusive.
REQ-003 SHALL have port Clk  in  1: the system clock, driven from CLOCK_50; the only clock.
REQ-004 SHALL have port Reset  in  1: synchronous, active-high reset.
REQ-005 SHALL have port frame_clk  in  1: VGA_VS level, sampled on Clk.
REQ-006 SHALL have port keycode  in  8: USB HID keycode from the NIOS PIO.
REQ-007 SHALL have ports green_y_pos, red_y_pos, yellow_y_pos, blue_y_pos, orange_y_pos  in  10 each: sprite rows.
REQ-008 SHALL have port score  out  16: four BCD digits, with [3:0] as the ones digit.
REQ-009 SHALL have port streak  out  8: count of consecutive hits.
REQ-010 SHALL have port hit_pulse  out  5: one-hot lane hit strobe, ordered {orange,blue,yellow,red,green}.
REQ-011 SHALL have port miss_pulse  out  1: miss strobe.
REQ-012 SHALL have port busy  out  1: high while the FSM is not in WAIT.

Function
REQ-013 SHALL map lanes as: 0x04 to green(0), 0x16 to red(1), 0x07 to yellow(2), 0x09 to blue(3), 0x0A to orange(4); any other code maps to no lane.
REQ-014 SHALL register keycode every cycle and detect a press when the new keycode maps to a lane and differs from the registered value.
REQ-015 SHALL detect a frame edge as a rising edge of frame_clk after a 2-flop synchronizer.
REQ-016 SHALL use FSM states WAIT, JUDGE, ADD0, ADD1, ADD2, ADD3, with WAIT as the reset state.
REQ-017 SHALL, in WAIT, latch the lane on a press and go to JUDGE the next cycle; presses while busy is high are dropped.
REQ-018 SHALL, in JUDGE, count a hit when the lane's y_pos is within [HIT_Y_MIN, HIT_Y_MAX] and the lane's lock bit is clear; otherwise it is a miss.
REQ-019 SHALL, on a hit, pulse hit_pulse[lane] for exactly one cycle (the JUDGE cycle), set lock[lane], saturate-increment streak at 255, and go to ADD0.
REQ-020 SHALL, on a miss, pulse miss_pulse for one cycle, clear streak to 0, and return to WAIT; score is unchanged.
REQ-021 SHALL, in ADD0..ADD3, add the increment to BCD digit n plus carry, one digit per cycle, then return to WAIT; the updated score is visible 5 cycles after JUDGE.
REQ-022 SHALL saturate score at 16'h9999 when digit 3 carries out.
REQ-023 SHALL keep score stable (old value) until the ADD3 write completes, with digit writes made in place.
REQ-024 SHALL, on each frame edge, clear lock[n] for every lane whose y_pos lies outside the window; a frame edge coinciding with JUDGE is evaluated after the JUDGE lock update.
REQ-025 SHALL compute the increment from the streak value before the JUDGE update.

Reset
REQ-026 SHALL, while Reset is high at a Clk edge: score=0, streak=0, hit_pulse=0, miss_pulse=0, busy=0, locks=0, FSM=WAIT, keycode register=0, and the synchronizer is cleared.
REQ-027 SHALL abort any in-progress ADD sequence on Reset, with no partial score retained.

Configuration
REQ-028 SHALL provide macro STREAK_MULT_EN; when defined, increment = 1 + min(streak/8, 3), giving a range of 1..4.
REQ-029 SHALL use an increment of 1 when STREAK_MULT_EN is not defined.

Verification
REQ-030 SHALL cover: green_y_pos=430, keycode 0x00 to 0x04 -> hit_pulse=5'b00001 for one cycle, streak=1, score=16'h0001 five cycles later.
REQ-031 SHALL cover: red_y_pos=100, keycode 0x16 -> miss_pulse one cycle, streak=0, score unchanged.
REQ-032 SHALL cover: a second 0x04 press (via 0x00) with green still at 430 and no frame edge -> miss (lock); then green_y_pos=470 plus a frame edge, green_y_pos=440 plus a frame edge, press -> hit.
REQ-033 SHALL cover: score preset to 16'h0999 via 999 hits, then one more hit -> 16'h1000; at 16'h9999, a hit -> stays 16'h9999.
REQ-034 SHALL cover: with STREAK_MULT_EN, streak=8 then a hit -> score +2; at streak=24 -> +4; without the macro -> +1.
REQ-035 SHALL cover: Reset asserted during ADD1 -> next cycle score=0, busy=0, FSM=WAIT.
